// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and defaults for the skid pipeline stage
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_BUBBLE = 0;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with valid bit, load enable and clear-to-fill
module pipe_slot #(
  parameter int W = 64,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (res || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= FILL;
    end else if (i_ld) begin
      r_valid <= 1'b1;
      r_data  <= i_d;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer decoupling upstream ready from downstream stall
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int LANES = 2,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(PIPE_BUBBLE)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);
  localparam int W = LANES * DATA_W;
  localparam logic [W-1:0] FILL = {LANES{BUBBLE}};
  state_t       r_state;
  logic         w_push, w_pop, w_skid_valid;
  logic         w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;
  logic [W-1:0] w_skid_data, w_main_d;
  // in_ready depends only on held state and reset, never on in_valid
  assign in_ready   = !w_skid_valid && !res;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_main_ld  = (r_state == EMPTY && w_push) || (r_state == BUSY && w_push && w_pop) ||
                      (r_state == FULL && w_pop);
  assign w_main_clr = flush || (r_state == BUSY && w_pop && !w_push);
  assign w_main_d   = r_state == FULL ? w_skid_data : in_data;
  assign w_skid_ld  = r_state == BUSY && w_push && !w_pop;
  assign w_skid_clr = flush || (r_state == FULL && w_pop);
  assign occupancy  = r_state;
  always_ff @(posedge clk) begin
    if (res || flush) r_state <= EMPTY;
    else
      case (r_state)
        EMPTY:   if (w_push) r_state <= BUSY;
        BUSY:    r_state <= w_push && !w_pop ? FULL : (!w_push && w_pop ? EMPTY : BUSY);
        FULL:    if (w_pop) r_state <= BUSY;
        default: r_state <= EMPTY;
      endcase
  end
  pipe_slot #(.W(W), .FILL(FILL)) u_main (
    .clk(clk), .res(res), .i_clr(w_main_clr), .i_ld(w_main_ld), .i_d(w_main_d),
    .o_valid(out_valid), .o_data(out_data)
  );
  pipe_slot #(.W(W), .FILL(FILL)) u_skid (
    .clk(clk), .res(res), .i_clr(w_skid_clr), .i_ld(w_skid_ld), .i_d(in_data),
    .o_valid(w_skid_valid), .o_data(w_skid_data)
  );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed scenarios plus a negedge scoreboard monitor
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] sb[$];
  logic [63:0] exp_d;

  pipe_skid_stage dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // scoreboard: inputs change at posedge+1, so negedge sees the values the next edge will use
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (occupancy !== 2'(sb.size())) $display("FAIL sb_occupancy got %0d want %0d", occupancy, sb.size());
      else n_pass++;
      if (!out_valid) begin
        n_chk++;
        if (out_data !== 64'd0) $display("FAIL sb_bubble got %h want 0", out_data);
        else n_pass++;
      end
      if (prev_stall) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("FAIL sb_stall_stable got %b/%h want 1/%h", out_valid, out_data, prev_data);
        else n_pass++;
      end
      prev_stall = out_valid && !out_ready && !res && !flush;
      prev_data  = out_data;
      if (res || flush) sb.delete();
      else begin
        if (out_valid && out_ready) begin
          n_chk++;
          if (sb.size() == 0) $display("FAIL sb_pop got %h want none", out_data);
          else begin
            exp_d = sb.pop_front();
            if (out_data !== exp_d) $display("FAIL sb_pop got %h want %h", out_data, exp_d);
            else n_pass++;
          end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; res = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    res = 1'b1;
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (occupancy !== 2'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
    n_chk++; if (out_data !== 64'd0) $display("FAIL rst_data got %h want 0", out_data); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
    mon_en = 1'b1;
    res = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_first_push();
    out_ready = 1'b1; in_valid = 1'b1; in_data = {32'h00A00093, 32'h00000004};
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL first_valid got %b want 1", out_valid); else n_pass++;
    n_chk++; if (out_data !== 64'h00A00093_00000004) $display("FAIL first_data got %h want 00a0009300000004", out_data); else n_pass++;
    n_chk++; if (occupancy !== 2'd1) $display("FAIL first_occ got %0d want 1", occupancy); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL first_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 64'(i)) $display("FAIL stream_%0d got %b/%h want 1/%h", i, out_valid, out_data, 64'(i));
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL stream_end got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hAAAA; tick();
    in_data = 64'hBBBB; tick();
    in_valid = 1'b0;
    n_chk++; if (occupancy !== 2'd2) $display("FAIL stall_occ got %0d want 2", occupancy); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_data !== 64'hAAAA) $display("FAIL stall_head got %h want aaaa", out_data); else n_pass++;
    out_ready = 1'b1; tick();
    n_chk++; if (out_data !== 64'hBBBB || out_valid !== 1'b1) $display("FAIL stall_second got %b/%h want 1/bbbb", out_valid, out_data); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL stall_ready_back got %b want 1", in_ready); else n_pass++;
    tick();
    n_chk++; if (occupancy !== 2'd0) $display("FAIL stall_drained got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic fill_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h1111; tick();
    in_data = 64'h2222; tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    fill_full();
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hCCCC; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 64'd0) $display("FAIL flush_data got %h want 0", out_data); else n_pass++;
    n_chk++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_no_emit got %b/%h want 0", out_valid, out_data); else n_pass++;
    end
  endtask

  task automatic test_reset_full();
    fill_full();
    res = 1'b1; flush = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rstfull_ready_in got %b want 0", in_ready); else n_pass++;
    tick();
    flush = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 64'd0)
      $display("FAIL rstfull_state got %b/%0d/%h want 0/0/0", out_valid, occupancy, out_data);
    else n_pass++;
    res = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rstfull_ready_after got %b want 1", in_ready); else n_pass++;
    out_ready = 1'b1; tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rstfull_no_emit got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = $urandom_range(0, 299) == 0;
      in_data   = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_chk++; if (sb.size() != 0) $display("FAIL random_drain got %0d left want 0", sb.size()); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL random_idle got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_push();
    idle();
    test_back_to_back();
    idle();
    test_stall();
    idle();
    test_flush();
    idle();
    test_reset_full();
    idle();
    test_random();
    idle();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
